// File: rtl/block_ram_reader_pkg.sv
// Shared parameter set for the block RAM read engine.
package block_ram_reader_pkg;

  // GPU-wide defaults for block RAM geometry.
  localparam int unsigned GpuWordWidth    = 32;
  localparam int unsigned GpuAddressWidth = 10;

  // The read engine never keeps more than this many words outstanding.
  localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/block_ram_reader_fifo2.sv
// Two-entry synchronous FIFO; simultaneous push and pop is allowed when full.
module block_ram_reader_fifo2
  import block_ram_reader_pkg::*;
#(
  parameter int unsigned WIDTH = GpuWordWidth
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  // A push into a full FIFO is only legal when paired with a pop.
  assign push_ok = push && ((count_q != 2'(FifoDepth)) || pop_ok);

  // Next-state: entry0 is always the head, entry1 the tail when two words are held.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) entry0_d = push_data;
        else                 entry1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          entry0_d = push_data;
        end else begin
          entry0_d = entry1_q;
          entry1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule

// File: rtl/block_ram_reader.sv
// Streams a run of block RAM words onto a valid/ready interface, hiding the
// RAM's one-cycle read latency and keeping at most two words outstanding.
module block_ram_reader
  import block_ram_reader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = GpuWordWidth,
  parameter int unsigned ADDRESS_WIDTH = GpuAddressWidth
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  output logic                     ram_read,
  input  logic [WORD_WIDTH-1:0]    ram_read_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_data,
  output logic                     out_last
);

  localparam int unsigned CountWidth = ADDRESS_WIDTH + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [CountWidth-1:0]   issue_left_q, issue_left_d;
  logic [CountWidth-1:0]   deliver_left_q, deliver_left_d;
  logic                    inflight_q;
  logic                    done_q, done_d;

  logic [1:0]              fifo_count;
  logic                    pop;
  logic [2:0]              occupancy;

  assign pop = out_valid && out_ready;

  // Words buffered or in flight after this cycle's pop; pop implies fifo_count >= 1.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

  assign ram_read = (state_q == StRun) && (issue_left_q != '0) &&
                    (occupancy < 3'(FifoDepth));
  assign ram_read_address = addr_q;

  // Next-state for the transfer FSM, address and counters.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    issue_left_d   = issue_left_q;
    deliver_left_d = deliver_left_q;
    done_d         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d         = start_address;
            issue_left_d   = word_count;
            deliver_left_d = word_count;
            state_d        = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (ram_read) begin
          addr_d       = addr_q + ADDRESS_WIDTH'(1);
          issue_left_d = issue_left_q - CountWidth'(1);
        end
        if (pop) begin
          deliver_left_d = deliver_left_q - CountWidth'(1);
          if (deliver_left_q == CountWidth'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; clearing inflight drops any RAM data still returning after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      inflight_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      issue_left_q   <= issue_left_d;
      deliver_left_q <= deliver_left_d;
      inflight_q     <= ram_read;
      done_q         <= done_d;
    end
  end

  block_ram_reader_fifo2 #(
    .WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (ram_read_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (out_data)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign out_last  = out_valid && (deliver_left_q == CountWidth'(1));
  assign busy      = (state_q == StRun);
  assign done      = done_q;

endmodule

// File: tb/tb_block_ram_reader.sv
// Directed bench for block_ram_reader: a 10-bit and a 4-bit address instance,
// each fed by a RAM model returning 0x1000 + address one cycle after a read.
module tb_block_ram_reader;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        start;
  logic [9:0]  start_address;
  logic [10:0] word_count;
  logic        busy, done, ram_read, out_valid, out_ready, out_last;
  logic [9:0]  ram_read_address;
  logic [31:0] ram_read_data, out_data;

  logic        b_start;
  logic [3:0]  b_start_address;
  logic [4:0]  b_word_count;
  logic        b_busy, b_done, b_ram_read, b_out_valid, b_out_ready, b_out_last;
  logic [3:0]  b_ram_read_address;
  logic [31:0] b_ram_read_data, b_out_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] data_log[$];
  logic        last_log[$];
  int          addr_log[$];
  logic [31:0] data4_log[$];
  int          addr4_log[$];
  int          done_cnt = 0, done4_cnt = 0, valid_cnt = 0, busy_cnt = 0;
  int          ncyc = 0, done_cyc = 0, last_hs_cyc = 0;

  always #5 clock = ~clock;

  block_ram_reader #(.WORD_WIDTH(32), .ADDRESS_WIDTH(10)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
    .word_count(word_count), .busy(busy), .done(done), .ram_read_address(ram_read_address),
    .ram_read(ram_read), .ram_read_data(ram_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  block_ram_reader #(.WORD_WIDTH(32), .ADDRESS_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(b_start), .start_address(b_start_address),
    .word_count(b_word_count), .busy(b_busy), .done(b_done),
    .ram_read_address(b_ram_read_address), .ram_read(b_ram_read),
    .ram_read_data(b_ram_read_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last)
  );

  // RAM models: registered read, contents 0x1000 + address.
  always @(posedge clock) begin
    if (ram_read) ram_read_data <= 32'h1000 + 32'(ram_read_address);
    if (b_ram_read) b_ram_read_data <= 32'h1000 + 32'(b_ram_read_address);
  end

  // Mid-cycle monitor: logs reads, handshakes (completing at the next edge) and done pulses.
  always @(negedge clock) begin
    ncyc <= ncyc + 1;
    if (ram_read) addr_log.push_back(int'(ram_read_address));
    if (out_valid && out_ready) begin
      data_log.push_back(out_data);
      last_log.push_back(out_last);
      last_hs_cyc <= ncyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= ncyc;
    end
    if (out_valid) valid_cnt <= valid_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (b_ram_read) addr4_log.push_back(int'(b_ram_read_address));
    if (b_out_valid && b_out_ready) data4_log.push_back(b_out_data);
    if (b_done) done4_cnt <= done4_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int base;
    base = done_cnt;
    for (int i = 0; i < maxc && done_cnt == base; i++) step();
    check(tag, 32'(done_cnt > base), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ram_read"}, 32'(ram_read), 32'd0);
    check({tag, "_addr"}, 32'(ram_read_address), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  // Compares the logged stream of the 10-bit instance against n words from a0.
  task automatic check_stream(input string tag, input int bd, input int ba, input int bdone,
                              input int a0, input int n);
    int exp_a;
    check({tag, "_nwords"}, 32'(data_log.size() - bd), 32'(n));
    check({tag, "_nreads"}, 32'(addr_log.size() - ba), 32'(n));
    for (int i = 0; i < n; i++) begin
      exp_a = (a0 + i) & 32'h3FF;
      check($sformatf("%s_addr%0d", tag, i), 32'(addr_log[ba + i]), 32'(exp_a));
      check($sformatf("%s_data%0d", tag, i), data_log[bd + i], 32'h1000 + 32'(exp_a));
      check($sformatf("%s_last%0d", tag, i), 32'(last_log[bd + i]), 32'(i == n - 1));
    end
    check({tag, "_done_once"}, 32'(done_cnt - bdone), 32'd1);
    check({tag, "_done_timing"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
  endtask

  initial begin
    int bd, ba, bdone, bv, bb, b4d, b4a, b4done;
    reset_n = 1'b0;
    start = 1'b0; start_address = '0; word_count = '0; out_ready = 1'b1;
    b_start = 1'b0; b_start_address = '0; b_word_count = '0; b_out_ready = 1'b1;
    step();
    step();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    step();

    // Basic 4-word transfer from address 8 with out_ready held high.
    bd = data_log.size(); ba = addr_log.size(); bdone = done_cnt;
    start_address = 10'd8; word_count = 11'd4; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_first_read", 32'(ram_read), 32'd1);
    check("t1_first_addr", 32'(ram_read_address), 32'd8);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    check("t1_no_valid_yet", 32'(out_valid), 32'd0);
    step();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_first_data", out_data, 32'h1008);
    wait_done("t1_wait_done", 20);
    step();
    step();
    check("t1_idle", 32'(busy), 32'd0);
    check_stream("t1", bd, ba, bdone, 8, 4);

    // Same transfer with a 5-cycle stall once the first word appears.
    bd = data_log.size(); ba = addr_log.size(); bdone = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t2_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    bb = addr_log.size();
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t2_hold_data%0d", i), out_data, 32'h1008);
    end
    check("t2_reads_while_stalled", 32'(addr_log.size() - bb <= 2), 32'd1);
    out_ready = 1'b1;
    wait_done("t2_wait_done", 20);
    step();
    check_stream("t2", bd, ba, bdone, 8, 4);

    // Address wrap on the 4-bit instance.
    b4d = data4_log.size(); b4a = addr4_log.size(); b4done = done4_cnt;
    b_start_address = 4'd14; b_word_count = 5'd4; b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 20 && done4_cnt == b4done; i++) step();
    check("t3_done", 32'(done4_cnt - b4done), 32'd1);
    check("t3_nwords", 32'(data4_log.size() - b4d), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_addr%0d", i), 32'(addr4_log[b4a + i]), 32'((14 + i) % 16));
      check($sformatf("t3_data%0d", i), data4_log[b4d + i], 32'h1000 + 32'((14 + i) % 16));
    end

    // Zero-length transfer.
    step();
    ba = addr_log.size(); bdone = done_cnt; bv = valid_cnt; bb = busy_cnt;
    start_address = 10'd5; word_count = 11'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("t4_done_pulse", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("t4_done_once", 32'(done_cnt - bdone), 32'd1);
    check("t4_no_reads", 32'(addr_log.size() - ba), 32'd0);
    check("t4_no_valid", 32'(valid_cnt - bv), 32'd0);
    check("t4_never_busy", 32'(busy_cnt - bb), 32'd0);

    // Reset in the middle of an 8-word transfer, then a clean 2-word transfer.
    bd = data_log.size();
    start_address = 10'h20; word_count = 11'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && data_log.size() < bd + 2; i++) step();
    check("t5_two_words_seen", 32'(data_log.size() - bd), 32'd2);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t5_reset");
    step();
    step();
    reset_n = 1'b1;
    step();
    bd = data_log.size(); ba = addr_log.size(); bdone = done_cnt;
    start_address = 10'd0; word_count = 11'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t5_wait_done", 20);
    step();
    check_stream("t5", bd, ba, bdone, 0, 2);

    // A second start mid-transfer must be ignored.
    bd = data_log.size(); ba = addr_log.size(); bdone = done_cnt;
    start_address = 10'h40; word_count = 11'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start_address = 10'h100; word_count = 11'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t6_wait_done", 20);
    for (int i = 0; i < 4; i++) step();
    check_stream("t6", bd, ba, bdone, 32'h40, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
